register_dump_reader: RTL and testbench

Debug readout engine for the multicycle CPU's general register file. On a start request it walks an inclusive address range through one register-file read port and streams each (address, data) pair out over a valid/ready handshake to the debug/trace link. It is the reader-side counterpart of the register file's write path: it only drives a read address and samples the combinational read data, and never writes.

---
 rtl/register_dump_reader_if.sv | 33 +++
 rtl/register_dump_reader.sv | 108 ++++++++++
 tb/tb_register_dump_reader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/register_dump_reader_if.sv
// Debug register-dump link: start/abort control, register-file read port and the
// valid/ready beat stream towards the trace link.
interface register_dump_reader_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
);
   logic              Start;
   logic              Abort;
   logic [ADDR_W-1:0] StartAddress;
   logic [ADDR_W-1:0] EndAddress;
   logic [ADDR_W-1:0] ReadRegAddress;
   logic [DATA_W-1:0] ReadData;
   logic              OutValid;
   logic              OutReady;
   logic [ADDR_W-1:0] OutAddress;
   logic [DATA_W-1:0] OutData;
   logic              OutLast;
   logic              Busy;
   logic              Done;
   logic              RangeError;

   // Reader side (the dump engine)
   modport master (
      input  Start, Abort, StartAddress, EndAddress, ReadData, OutReady,
      output ReadRegAddress, OutValid, OutAddress, OutData, OutLast, Busy, Done, RangeError
   );

   // Requester / register file / trace link side
   modport slave (
      output Start, Abort, StartAddress, EndAddress, ReadData, OutReady,
      input  ReadRegAddress, OutValid, OutAddress, OutData, OutLast, Busy, Done, RangeError
   );
endinterface

// File: rtl/register_dump_reader.sv
// Walks an inclusive register range through one read port of the register file and
// streams (address, data) beats out over valid/ready. Read-only: never writes.
module register_dump_reader #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input logic                    Clock,
   input logic                    Reset,
   register_dump_reader_if.master bus
);

   typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} stateT;

   stateT             stateQ, stateD;
   logic [ADDR_W-1:0] pointerQ, pointerD;
   logic [ADDR_W-1:0] endQ, endD;
   logic [ADDR_W-1:0] outAddressQ, outAddressD;
   logic [DATA_W-1:0] outDataQ, outDataD;
   logic              outLastQ, outLastD;
   logic              rangeErrorQ, rangeErrorD;

   // Next-state, pointer advance and beat capture
   always_comb begin
      stateD      = stateQ;
      pointerD    = pointerQ;
      endD        = endQ;
      outAddressD = outAddressQ;
      outDataD    = outDataQ;
      outLastD    = outLastQ;
      rangeErrorD = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (bus.Start) begin
               pointerD = bus.StartAddress;
               endD     = bus.EndAddress;
               if (bus.EndAddress >= bus.StartAddress) begin
                  stateD = StFetch;
               end else begin
                  rangeErrorD = 1'b1;
               end
            end
         end
         StFetch: begin
            if (bus.Abort) begin
               stateD = StIdle;
            end else begin
               // Read data is combinational; capture it at the edge ending FETCH
               outDataD    = bus.ReadData;
               outAddressD = pointerQ;
               outLastD    = (pointerQ == endQ);
               stateD      = StSend;
            end
         end
         StSend: begin
            if (bus.Abort) begin
               // Abort beats an accepted last beat, so no Done is issued
               stateD = StIdle;
            end else if (bus.OutReady) begin
               if (outLastQ) begin
                  stateD = StDone;
               end else begin
                  // Only advance when not last, so a range ending at the top never wraps
                  pointerD = pointerQ + ADDR_W'(1);
                  stateD   = StFetch;
               end
            end
         end
         StDone: begin
            stateD = StIdle;
         end
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         stateQ      <= StIdle;
         pointerQ    <= '0;
         endQ        <= '0;
         outAddressQ <= '0;
         outDataQ    <= '0;
         outLastQ    <= 1'b0;
         rangeErrorQ <= 1'b0;
      end else begin
         stateQ      <= stateD;
         pointerQ    <= pointerD;
         endQ        <= endD;
         outAddressQ <= outAddressD;
         outDataQ    <= outDataD;
         outLastQ    <= outLastD;
         rangeErrorQ <= rangeErrorD;
      end
   end

   // Read address is parked at 0 while idle so the port is quiet between dumps
   assign bus.ReadRegAddress = (stateQ == StIdle) ? '0 : pointerQ;
   assign bus.OutValid       = (stateQ == StSend);
   assign bus.OutAddress     = outAddressQ;
   assign bus.OutData        = outDataQ;
   assign bus.OutLast        = outLastQ;
   assign bus.Busy           = (stateQ != StIdle);
   assign bus.Done           = (stateQ == StDone);
   assign bus.RangeError     = rangeErrorQ;

endmodule

// File: tb/tb_register_dump_reader.sv
// Randomized bench for register_dump_reader: a register-file array feeds the read
// port and every dump is checked against the beat sequence the range implies.
module tb_register_dump_reader;

   logic        Clock;
   logic        Reset;
   logic [31:0] rf   [32];
   logic [31:0] snap [32];
   int          checks;
   int          failures;

   register_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   register_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   // Register file read port: r0 is hard-wired to zero
   assign bus.ReadData = (bus.ReadRegAddress == 5'd0) ? 32'd0 : rf[bus.ReadRegAddress];

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic checkValue(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idleInputs();
      bus.Start        = 1'b0;
      bus.Abort        = 1'b0;
      bus.OutReady     = 1'b0;
      bus.StartAddress = 5'd0;
      bus.EndAddress   = 5'd0;
   endtask

   // One dump request. Expected beats are sa..ea with the register values as they
   // stood when each was fetched; abortBeat < 0 means no abort.
   task automatic runDump(input logic [4:0] sa, input logic [4:0] ea, input int readyPct,
                          input int abortBeat, input int stallBeat, input int stallLen,
                          input bit lateWrite, input bit timing);
      int         nBeats;
      int         beat;
      int         cyc;
      int         stallLeft;
      int         lastSeen;
      bit         aborted;
      bit         finished;
      logic [4:0] addr;
      for (int i = 0; i < 32; i++) snap[i] = (i == 0) ? 32'd0 : rf[i];
      bus.Start        = 1'b1;
      bus.StartAddress = sa;
      bus.EndAddress   = ea;
      bus.OutReady     = 1'b0;
      bus.Abort        = 1'b0;
      tick();
      bus.Start = 1'b0;
      if (ea < sa) begin
         checkValue("rangeErrPulse", bus.RangeError, 1);
         checkValue("rangeErrBusy", bus.Busy, 0);
         checkValue("rangeErrValid", bus.OutValid, 0);
         tick();
         checkValue("rangeErrEnd", bus.RangeError, 0);
         checkValue("rangeErrDone", bus.Done, 0);
         checkValue("rangeErrBusy2", bus.Busy, 0);
         return;
      end
      nBeats = int'(ea) - int'(sa) + 1;
      checkValue("startBusy", bus.Busy, 1);
      checkValue("startValid", bus.OutValid, 0);
      checkValue("startReadAddr", bus.ReadRegAddress, sa);
      if (lateWrite && sa != 5'd0) begin
         // Falling-edge write inside the first FETCH must show up in the beat
         @(negedge Clock);
         rf[sa]   = 32'hCAFE_0000 | 32'(sa);
         snap[sa] = rf[sa];
      end
      beat      = 0;
      stallLeft = 0;
      lastSeen  = -1;
      aborted   = 1'b0;
      finished  = 1'b0;
      for (cyc = 1; cyc < 400 && !finished; cyc++) begin
         tick();
         addr = sa + 5'(beat);
         if (aborted) begin
            bus.Abort = 1'b0;
            checkValue("abortValid", bus.OutValid, 0);
            checkValue("abortBusy", bus.Busy, 0);
            checkValue("abortDone", bus.Done, 0);
            tick();
            checkValue("abortDone2", bus.Done, 0);
            finished = 1'b1;
         end else if (bus.Done) begin
            checkValue("doneBeats", beat, nBeats);
            checkValue("doneBusy", bus.Busy, 1);
            checkValue("doneValid", bus.OutValid, 0);
            if (timing) checkValue("doneCycle", cyc, 2 * nBeats);
            bus.OutReady = 1'b0;
            tick();
            checkValue("postDone", bus.Done, 0);
            checkValue("postBusy", bus.Busy, 0);
            checkValue("postReadAddr", bus.ReadRegAddress, 0);
            finished = 1'b1;
         end else if (bus.OutValid) begin
            if (timing && beat == 0) checkValue("firstValidCycle", cyc, 1);
            checkValue("beatAddr", bus.OutAddress, addr);
            checkValue("beatData", bus.OutData, snap[addr]);
            checkValue("beatLast", bus.OutLast, (beat == nBeats - 1));
            checkValue("beatBusy", bus.Busy, 1);
            if (beat != lastSeen) begin
               lastSeen = beat;
               if (beat == stallBeat) stallLeft = stallLen;
            end
            if (stallLeft > 0) begin
               // Writes after the sampling edge must not leak into the held beat
               stallLeft--;
               bus.OutReady = 1'b0;
               if (addr != 5'd0) rf[addr] = $urandom;
            end else begin
               bus.OutReady = ($urandom_range(99) < readyPct);
            end
            if (beat == abortBeat) begin
               bus.Abort = 1'b1;
               aborted   = 1'b1;
            end else if (bus.OutReady) begin
               beat++;
            end
         end else begin
            checkValue("fetchBusy", bus.Busy, 1);
            checkValue("fetchReadAddr", bus.ReadRegAddress, addr);
            bus.OutReady = ($urandom_range(1) == 1);
         end
      end
      if (!finished) checkValue("timeout", 0, 1);
      idleInputs();
   endtask

   initial begin
      logic [4:0] sa;
      logic [4:0] ea;
      int         ab;
      checks   = 0;
      failures = 0;
      idleInputs();
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      Reset = 1'b1;
      tick();
      tick();
      checkValue("rstValid", bus.OutValid, 0);
      checkValue("rstBusy", bus.Busy, 0);
      checkValue("rstReadAddr", bus.ReadRegAddress, 0);
      checkValue("rstOutData", bus.OutData, 0);
      checkValue("rstOutAddr", bus.OutAddress, 0);
      checkValue("rstDoneErr", {bus.Done, bus.RangeError, bus.OutLast}, 0);
      Reset = 1'b0;
      tick();
      checkValue("idleBusy", bus.Busy, 0);

      // Single register with exact latency
      rf[5] = 32'hDEAD_BEEF;
      runDump(5'd5, 5'd5, 100, -1, -1, 0, 1'b0, 1'b1);

      // Full range, ends at 31 without wrapping
      for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h1111_1111;
      runDump(5'd0, 5'd31, 100, -1, -1, 0, 1'b0, 1'b1);

      // Backpressure on the second beat
      runDump(5'd1, 5'd3, 100, -1, 1, 4, 1'b0, 1'b0);

      // Inverted range
      runDump(5'd9, 5'd4, 100, -1, -1, 0, 1'b0, 1'b0);

      // Abort during beat 3, then a fresh single-register dump
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      runDump(5'd1, 5'd10, 100, 2, -1, 0, 1'b0, 1'b0);
      runDump(5'd2, 5'd2, 100, -1, -1, 0, 1'b0, 1'b1);

      // Falling-edge write during FETCH is reflected
      runDump(5'd6, 5'd6, 100, -1, -1, 0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a SEND
      bus.Start        = 1'b1;
      bus.StartAddress = 5'd0;
      bus.EndAddress   = 5'd7;
      tick();
      bus.Start = 1'b0;
      tick();
      checkValue("preRstValid", bus.OutValid, 1);
      #3;
      Reset = 1'b1;
      #1;
      checkValue("asyncRstValid", bus.OutValid, 0);
      checkValue("asyncRstBusy", bus.Busy, 0);
      checkValue("asyncRstReadAddr", bus.ReadRegAddress, 0);
      tick();
      checkValue("heldRstValid", bus.OutValid, 0);
      checkValue("heldRstOut", {bus.OutAddress, bus.OutData, bus.OutLast}, 0);
      Reset = 1'b0;
      idleInputs();
      tick();

      // Random ranges, readiness and aborts
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 32; i++) rf[i] = $urandom;
         sa = 5'($urandom_range(31));
         ea = ($urandom_range(7) == 0) ? 5'($urandom_range(31))
                                       : 5'(int'(sa) + $urandom_range(31 - int'(sa)));
         ab = ($urandom_range(3) == 0) ? $urandom_range(int'(ea) - int'(sa) + 1) : -1;
         if (ea < sa) ab = -1;
         runDump(sa, ea, $urandom_range(30, 100), ab, $urandom_range(3), $urandom_range(3),
                 ($urandom_range(1) == 1), 1'b0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
